vrc_evaluator: RTL and testbench



---
 rtl/vrc_evaluator.sv | 167 ++++++++++++++++
 tb/tb_vrc_evaluator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vrc_evaluator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vrc_evaluator: sweeps all input vectors through a genome-defined gate    |
// | network and scores stable outputs against a target truth table.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vrc_evaluator #(
    parameter int N_IN    = 5,
    parameter int N_GATES = 11,
    parameter int N_OUT   = 1,
    parameter int SETTLE  = 4,
    localparam int SEL_W   = $clog2(N_IN + N_GATES),
    localparam int CFG_W   = 3 + 2 * SEL_W,
    localparam int ADDR_W  = $clog2(N_GATES + N_OUT),
    localparam int NVEC    = 2 ** N_IN,
    localparam int SCORE_W = $clog2(N_OUT * NVEC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic [N_OUT*NVEC-1:0] target,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [SCORE_W-1:0]    score,
    output logic [N_IN:0]         unstable_count
);
    localparam int POOL_W = 2 ** SEL_W;
    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMP1  = 3'd3,
        S_SAMP2  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CFG_W-1:0]    gate_cfg_q [N_GATES];
    logic [SEL_W-1:0]    out_sel_q  [N_OUT];
    logic [N_GATES-1:0]  gate_q, gate_d;
    logic [N_IN-1:0]     vec_q, cnt_q;
    logic [SCNT_W-1:0]   settle_q;
    logic [N_OUT-1:0]    samp_q, cur_out, tgt_bit;
    logic [SCORE_W-1:0]  score_q, score_inc;
    logic [N_IN:0]       unstable_q;
    logic                any_diff;
    logic [POOL_W-1:0]   pool;

    function automatic logic gate_fn(input logic [2:0] f, input logic a, input logic b);
        case (f)
            3'd0:    gate_fn = a & b;
            3'd1:    gate_fn = a | b;
            3'd2:    gate_fn = ~(a & b);
            3'd3:    gate_fn = ~(a | b);
            3'd4:    gate_fn = a ^ b;
            3'd5:    gate_fn = ~(a ^ b);
            3'd6:    gate_fn = ~a;
            default: gate_fn = a;
        endcase
    endfunction

    // Source pool: vector bits, then gate outputs, unused codes read as 0.
    always_comb begin
        pool = '0;
        pool[N_IN+N_GATES-1:0] = {gate_q, vec_q};
    end

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        assign gate_d[g] = gate_fn(gate_cfg_q[g][2:0],
                                   pool[gate_cfg_q[g][SEL_W+2:3]],
                                   pool[gate_cfg_q[g][2*SEL_W+2:SEL_W+3]]);
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        logic [NVEC-1:0] tvec;
        assign tvec       = target[k*NVEC +: NVEC];
        assign tgt_bit[k] = tvec[cnt_q];
        assign cur_out[k] = pool[out_sel_q[k]];
    end

    always_comb begin
        score_inc = '0;
        any_diff  = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (cur_out[k] != samp_q[k]) begin
                any_diff = 1'b1;
            end else if (cur_out[k] == tgt_bit[k]) begin
                score_inc = score_inc + SCORE_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_APPLY;
            S_APPLY:  state_d = S_SETTLE;
            S_SETTLE: if (settle_q == SETTLE_LAST) state_d = S_SAMP1;
            S_SAMP1:  state_d = S_SAMP2;
            S_SAMP2:  state_d = (cnt_q == '1) ? S_DONE : S_APPLY;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_q     <= '0;
            vec_q      <= '0;
            cnt_q      <= '0;
            settle_q   <= '0;
            samp_q     <= '0;
            score_q    <= '0;
            unstable_q <= '0;
            for (int g = 0; g < N_GATES; g++) gate_cfg_q[g] <= '0;
            for (int k = 0; k < N_OUT; k++)   out_sel_q[k]  <= '0;
        end else begin
            // Gates free-run every cycle; state deliberately carries across vectors.
            gate_q <= gate_d;
            case (state_q)
                S_IDLE: begin
                    if (cfg_we) begin
                        for (int g = 0; g < N_GATES; g++)
                            if (cfg_addr == ADDR_W'(g)) gate_cfg_q[g] <= cfg_data;
                        for (int k = 0; k < N_OUT; k++)
                            if (cfg_addr == ADDR_W'(N_GATES + k)) out_sel_q[k] <= cfg_data[SEL_W-1:0];
                    end
                    if (start) begin
                        gate_q     <= '0;
                        cnt_q      <= '0;
                        score_q    <= '0;
                        unstable_q <= '0;
                    end
                end
                S_APPLY: begin
                    vec_q    <= cnt_q;
                    settle_q <= '0;
                end
                S_SETTLE: settle_q <= settle_q + SCNT_W'(1);
                S_SAMP1:  samp_q   <= cur_out;
                S_SAMP2: begin
                    score_q <= score_q + score_inc;
                    if (any_diff) unstable_q <= unstable_q + 1'b1;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign score          = score_q;
    assign unstable_count = unstable_q;
endmodule
`default_nettype wire

// File: tb/tb_vrc_evaluator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vrc_evaluator: table, directed and random checks against a LUT model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vrc_evaluator;
    localparam int N_IN = 5, N_GATES = 11, N_OUT = 1, SETTLE = 4;
    localparam int NVEC = 32, SEL_W = 4, CFG_W = 11, ADDR_W = 4, SCORE_W = 6;
    localparam int LAT  = NVEC * (SETTLE + 3) + 1;

    logic                clk = 1'b0;
    logic                rst_n, cfg_we, start;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [CFG_W-1:0]    cfg_data;
    logic [NVEC-1:0]     target;
    logic                busy, done;
    logic [SCORE_W-1:0]  score;
    logic [N_IN:0]       unstable_count;

    int checks = 0, failures = 0;

    // Model state: genome copy and the applied-vector register that carries between runs.
    logic [CFG_W-1:0] m_cfg [N_GATES];
    logic [SEL_W-1:0] m_sel;
    logic [N_IN-1:0]  m_vec;
    logic [3:0]       LUT [8];

    typedef struct {
        string            name;
        logic [CFG_W-1:0] cfg0;
        int               sel;
        logic [NVEC-1:0]  tgt;
        int               exp_s;
        int               exp_u;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    vrc_evaluator #(.N_IN(N_IN), .N_GATES(N_GATES), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .target(target), .start(start), .busy(busy), .done(done),
        .score(score), .unstable_count(unstable_count)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk(input int f, input int a, input int b);
        return {4'(b), 4'(a), 3'(f)};
    endfunction

    function automatic logic [NVEC-1:0] pat(input int kind);
        logic [NVEC-1:0] t;
        logic [N_IN-1:0] b;
        for (int v = 0; v < NVEC; v++) begin
            b = N_IN'(v);
            case (kind)
                0:       t[v] = b[0] ^ b[1];
                1:       t[v] = b[0] & b[1];
                2:       t[v] = ~(b[3] | b[4]);
                3:       t[v] = b[2];
                4:       t[v] = b[1];
                default: t[v] = 1'b0;
            endcase
        end
        return t;
    endfunction

    function automatic logic m_src(input int s, input logic [N_GATES-1:0] g, input logic [N_IN-1:0] vec);
        if (s < N_IN) return vec[s];
        if (s < N_IN + N_GATES) return g[s-N_IN];
        return 1'b0;
    endfunction

    function automatic logic [N_GATES-1:0] m_step(input logic [N_GATES-1:0] g, input logic [N_IN-1:0] vec);
        logic [N_GATES-1:0] n;
        logic [3:0] tt;
        logic a, b;
        for (int i = 0; i < N_GATES; i++) begin
            a     = m_src(int'(m_cfg[i][6:3]), g, vec);
            b     = m_src(int'(m_cfg[i][10:7]), g, vec);
            tt    = LUT[m_cfg[i][2:0]];
            n[i]  = tt[{a, b}];
        end
        return n;
    endfunction

    // One whole sweep: APPLY step, SETTLE steps, then two sampled steps.
    task automatic model_run(output int sc, output int un);
        logic [N_GATES-1:0] g;
        logic [N_IN-1:0]    vec;
        logic               o1, o2;
        g = '0; vec = m_vec; sc = 0; un = 0;
        for (int v = 0; v < NVEC; v++) begin
            g   = m_step(g, vec);
            vec = N_IN'(v);
            for (int s = 0; s < SETTLE; s++) g = m_step(g, vec);
            o1 = m_src(int'(m_sel), g, vec);
            g  = m_step(g, vec);
            o2 = m_src(int'(m_sel), g, vec);
            g  = m_step(g, vec);
            if (o1 != o2) un++;
            else if (o2 == target[v]) sc++;
        end
        m_vec = vec;
    endtask

    task automatic cfg_write(input int a, input logic [CFG_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (a < N_GATES) m_cfg[a] = d;
        else if (a < N_GATES + N_OUT) m_sel = d[SEL_W-1:0];
    endtask

    task automatic set_genome(input logic [CFG_W-1:0] c0, input int sel);
        for (int g = 0; g < N_GATES; g++) cfg_write(g, (g == 0) ? c0 : '0);
        cfg_write(N_GATES, CFG_W'(sel));
    endtask

    task automatic do_run(input string nm, input int exp_s, input int exp_u,
                          input int wr_at, input logic [ADDR_W-1:0] wa, input logic [CFG_W-1:0] wd);
        int k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        k = 1;
        check({nm, " busy_after_start"}, int'(busy), 1);
        while (!done && k < LAT + 20) begin
            if (k == wr_at) begin cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; end
            @(negedge clk);
            cfg_we = 1'b0;
            k++;
        end
        check({nm, " done_latency"}, k, LAT);
        check({nm, " score"}, int'(score), exp_s);
        check({nm, " unstable"}, int'(unstable_count), exp_u);
        @(negedge clk);
        check({nm, " done_single"}, int'(done), 0);
        check({nm, " idle_after"}, int'(busy), 0);
        check({nm, " score_hold"}, int'(score), exp_s);
    endtask

    initial begin
        int ms, mu, pulses;
        LUT = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
        tbl[0] = '{"osc",      mk(6, 5, 0), 5, pat(0),  0, 32};
        tbl[1] = '{"xor",      mk(4, 0, 1), 5, pat(0), 32,  0};
        tbl[2] = '{"xor_inv",  mk(4, 0, 1), 5, ~pat(0), 0,  0};
        tbl[3] = '{"and",      mk(0, 0, 1), 5, pat(1), 32,  0};
        tbl[4] = '{"nor34",    mk(3, 3, 4), 5, pat(2), 32,  0};
        tbl[5] = '{"direct2",  mk(4, 0, 1), 2, pat(3), 32,  0};
        tbl[6] = '{"direct2n", mk(4, 0, 1), 2, ~pat(3), 0,  0};
        tbl[7] = '{"buf1",     mk(7, 1, 0), 5, pat(4), 32,  0};

        rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_data = '0; target = '0;
        for (int g = 0; g < N_GATES; g++) m_cfg[g] = '0;
        m_sel = '0; m_vec = '0;
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset score", int'(score), 0);
        check("reset unstable", int'(unstable_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            set_genome(tbl[i].cfg0, tbl[i].sel);
            target = tbl[i].tgt;
            model_run(ms, mu);
            do_run(tbl[i].name, tbl[i].exp_s, tbl[i].exp_u, -1, '0, '0);
        end

        // Output selector write while busy is dropped; the same write when idle sticks.
        set_genome(mk(4, 0, 1), 5);
        target = pat(0);
        model_run(ms, mu);
        do_run("busy_write", 32, 0, 50, ADDR_W'(N_GATES), '0);
        cfg_write(12, CFG_W'(5));
        cfg_write(15, CFG_W'(5));
        cfg_write(N_GATES, '0);
        model_run(ms, mu);
        do_run("idle_write", 16, 0, -1, '0, '0);

        // Write and start in the same idle cycle.
        cfg_we = 1'b1; cfg_addr = ADDR_W'(N_GATES); cfg_data = CFG_W'(5);
        m_sel = 4'd5;
        model_run(ms, mu);
        do_run("write_with_start", 32, 0, -1, '0, '0);

        // Back-to-back: second start in the idle cycle right after done.
        model_run(ms, mu);
        do_run("b2b", 32, 0, -1, '0, '0);

        // Reset in the middle of vector 10.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (73) @(negedge clk);
        check("pre_reset score_nonzero", int'(score != 0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset score", int'(score), 0);
        check("midreset unstable", int'(unstable_count), 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midreset no_done", pulses, 0);
        for (int g = 0; g < N_GATES; g++) m_cfg[g] = '0;
        m_sel = '0; m_vec = '0;
        model_run(ms, mu);
        do_run("genome_reset", ms, mu, -1, '0, '0);
        set_genome(mk(4, 0, 1), 5);
        model_run(ms, mu);
        do_run("post_reset_xor", 32, 0, -1, '0, '0);

        // Random genomes and targets against the model.
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < N_GATES; g++) cfg_write(g, CFG_W'($urandom));
            cfg_write(N_GATES, CFG_W'($urandom_range(0, 15)));
            target = NVEC'($urandom);
            model_run(ms, mu);
            do_run($sformatf("rand%0d", r), ms, mu, -1, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
